alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//   Execute-stage input register sitting directly upstream of the ALU: latches decoded op (mode, operands, rd)
//   under valid/ready handshake and drives the ALU's mode/op1/op2 from registers.
//   Resolves operands from register-file read data, immediate, or write-back bypass; refreshes held operands
//   while stalled so the ALU never consumes a stale register value.
// PARAMETERS
//   DATA_WIDTH  32  operand/immediate width (matches ALU)
//   ADDR_WIDTH  5   register address width; register 0 reads as constant zero
// PORTS
//   clk          in   1           clock, all state on rising edge
//   rst_n        in   1           asynchronous reset, active-low
//   flush        in   1           kill held op (branch taken)
//   in_valid     in   1           decode offers an op
//   in_ready     out  1           stage accepts op this cycle
//   in_mode      in   3           ALU mode (alu_mode_t)
//   in_rs1/rs2   in   ADDR_WIDTH  source register addresses
//   in_rd        in   ADDR_WIDTH  destination register address
//   in_use_imm   in   1           op2 = in_imm instead of rs2
//   in_imm       in   DATA_WIDTH  sign-extended immediate
//   rf_rd1/rd2   in   DATA_WIDTH  register-file async read data for in_rs1/in_rs2, same cycle
//   wb_valid     in   1           write-back commits this cycle
//   wb_addr      in   ADDR_WIDTH  write-back register
//   wb_data      in   DATA_WIDTH  write-back value
//   ex_valid     out  1           ALU inputs valid
//   ex_ready     in   1           downstream consumes ALU result this cycle
//   ex_mode      out  3           to ALU mode
//   ex_op1/op2   out  DATA_WIDTH  to ALU op1/op2
//   ex_rd        out  ADDR_WIDTH  destination, passed alongside ALU result
// BEHAVIOUR
//   - Reset (async, rst_n=0): ex_valid=0, ex_mode=0 (ADD), ex_op1=ex_op2=0, ex_rd=0, held rs1/rs2/use_imm=0; FSM=EMPTY.
//   - FSM: EMPTY (ex_valid=0) / FULL (ex_valid=1). in_ready = EMPTY | ex_ready (combinational, no bubble).
//   - Accept = in_valid & in_ready. EMPTY: accept->FULL. FULL: ex_ready & accept->FULL (new op);
//     ex_ready & !accept->EMPTY; !ex_ready->FULL, outputs hold (except bypass refresh).
//   - flush: next edge -> EMPTY regardless of accept/ex_ready; in_ready forced 0 while flush=1.
//   - Latency: op accepted on edge N appears at ex_* after edge N (1 cycle), stays until ex_ready.
//   - Operand select at accept: rsX==0 -> 0; else wb_valid & wb_addr==rsX -> wb_data; else rf_rdX.
//     op2 = in_imm when in_use_imm (rs2 ignored, no bypass). wb_addr==0 never forwards.
//   - Held refresh: in FULL & !ex_ready, wb_valid & wb_addr!=0 & wb_addr==held rs1 -> ex_op1<=wb_data;
//     same for rs2 when !held use_imm. Both operands may refresh in one cycle.
//   - No arithmetic on data; widths pass through unchanged; ex_mode copied verbatim (all 8 codes legal).
//   - Reset mid-op: held op discarded, no partial output.
// CONFIGURATION
//   ALU_ISSUE_FORWARD_EN defined: write-back bypass at accept and held refresh as above.
//   Undefined: operands always rf_rdX (or 0 / imm); no refresh; wb_* ports present but ignored;
//     decode stalls on hazards externally.
// STRUCTURE
//   cpu_pkg: alu_mode_t enum (ADD=0,SUB,AND,OR,XOR,SLL,SRL,PASS=7), REG_ADDR_WIDTH, ZERO_REG=0,
//     issue_state_t {EMPTY,FULL}.
//   Sub-module operand_bypass (combinational: addr, rf_data, wb_* -> data), instantiated twice.
// TESTING
//   Reset: rst_n=0 mid-FULL -> ex_valid=0, ex_op1=0 immediately, in_ready=1 after release.
//   Streaming: in_valid=1, ex_ready=1, ops rs1=1(rf=5) rs2=2(rf=7) mode=0 -> ex_op1=5, ex_op2=7 next cycle, no bubbles over 8 ops.
//   Stall: ex_ready=0 for 3 cycles -> in_ready=0, ex_* stable; ex_ready=1 -> next op appears following cycle.
//   Bypass: rs1=3 rf=0x11, wb_valid=1 wb_addr=3 wb_data=0xAA same cycle -> ex_op1=0xAA; wb_addr=0 -> no forward, x0 reads 0.
//   Held refresh: FULL rs2=4 stalled, wb writes r4=0x55 -> ex_op2=0x55 next cycle; use_imm=1 -> op2 stays imm.
//   Flush: flush=1 with in_valid=1, ex_ready=0 -> ex_valid=0 next cycle, op not accepted.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU-wide types and constants.
//   alu_mode_t    - ALU operation codes. All eight codes are legal.
//   issue_state_t - occupancy state of the ALU issue register. Its values are
//                   the constants EMPTY and FULL.
//   REG_ADDR_WIDTH, ZERO_REG - register file geometry. Register 0 is hardwired
//                   to zero.
package cpu_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int ZERO_REG       = 0;

    typedef enum logic [2:0] {
        ADD  = 3'd0,
        SUB  = 3'd1,
        AND  = 3'd2,
        OR   = 3'd3,
        XOR  = 3'd4,
        SLL  = 3'd5,
        SRL  = 3'd6,
        PASS = 3'd7
    } alu_mode_t;

    // A plain one-bit vector with named constants keeps this type compatible
    // with older tools that only accept constant-encoded state registers.
    typedef logic [0:0] issue_state_t;
    localparam issue_state_t EMPTY = 1'b0;
    localparam issue_state_t FULL  = 1'b1;

endpackage

// File: rtl/operand_bypass.sv
// operand_bypass: combinational source-operand resolver.
// Optional feature macro: ALU_ISSUE_FORWARD_EN (write-back forwarding).
// Ports:
//   addr     in  ADDR_WIDTH  source register address
//   rf_data  in  DATA_WIDTH  register-file read data for addr
//   wb_valid in  1           write-back commits this cycle
//   wb_addr  in  ADDR_WIDTH  write-back register
//   wb_data  in  DATA_WIDTH  write-back value
//   data     out DATA_WIDTH  resolved operand value
// Register 0 always resolves to zero. When forwarding is built in, a
// same-cycle write-back to addr takes priority over the register file. The
// wb_* inputs are ignored when forwarding is not built in.
module operand_bypass
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] rf_data,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [DATA_WIDTH-1:0] data
);

    // The zero-register check comes first. Because of that, a write-back
    // aimed at x0 can never be forwarded.
    always_comb begin
        data = rf_data;
        if (addr == ADDR_WIDTH'(ZERO_REG)) begin
            data = '0;
        end
`ifdef ALU_ISSUE_FORWARD_EN
        else if (wb_valid && (wb_addr == addr)) begin
            data = wb_data;
        end
`endif
    end

`ifndef ALU_ISSUE_FORWARD_EN
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_addr, wb_data};
`endif

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: execute-stage input register placed in front of the ALU.
// Optional feature macro: ALU_ISSUE_FORWARD_EN. When defined, the stage
//   forwards write-back data when it accepts an op, and refreshes the held
//   operands while stalled.
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   flush                 kills the held op; blocks acceptance while high
//   in_valid / in_ready   decode-side handshake
//   in_mode, in_rs1, in_rs2, in_rd, in_use_imm, in_imm
//                         decoded op
//   rf_rd1 / rf_rd2       async register-file read data for in_rs1 / in_rs2
//   wb_valid, wb_addr, wb_data
//                         write-back port, used for forwarding
//   ex_valid / ex_ready   ALU-side handshake
//   ex_mode, ex_op1, ex_op2, ex_rd
//                         registered ALU inputs and destination
module alu_issue_stage
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            in_mode,
    input  logic [ADDR_WIDTH-1:0] in_rs1,
    input  logic [ADDR_WIDTH-1:0] in_rs2,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_use_imm,
    input  logic [DATA_WIDTH-1:0] in_imm,
    input  logic [DATA_WIDTH-1:0] rf_rd1,
    input  logic [DATA_WIDTH-1:0] rf_rd2,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [2:0]            ex_mode,
    output logic [DATA_WIDTH-1:0] ex_op1,
    output logic [DATA_WIDTH-1:0] ex_op2,
    output logic [ADDR_WIDTH-1:0] ex_rd
);

    issue_state_t          state;
    logic [ADDR_WIDTH-1:0] held_rs1;
    logic [ADDR_WIDTH-1:0] held_rs2;
    logic                  held_use_imm;
    logic [DATA_WIDTH-1:0] op1_sel;
    logic [DATA_WIDTH-1:0] op2_reg;
    logic [DATA_WIDTH-1:0] op2_sel;
    logic                  accept;
    logic                  refresh1;
    logic                  refresh2;

    // A FULL register can take a new op in the same cycle the ALU drains the
    // current one, so back-to-back ops need no bubble. flush overrides this
    // and blocks acceptance so the killed slot stays empty.
    assign in_ready = !flush && ((state == EMPTY) || ex_ready);
    assign accept   = in_valid && in_ready;
    assign ex_valid = (state == FULL);

    operand_bypass #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bypass_rs1 (
        .addr     (in_rs1),
        .rf_data  (rf_rd1),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .data     (op1_sel)
    );

    operand_bypass #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bypass_rs2 (
        .addr     (in_rs2),
        .rf_data  (rf_rd2),
        .wb_valid (wb_valid),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .data     (op2_reg)
    );

    // An immediate operand replaces rs2 completely, so no bypass applies.
    assign op2_sel = in_use_imm ? in_imm : op2_reg;

    // While the op is stalled, a write-back to one of its source registers
    // overwrites the captured value. This keeps the ALU from consuming stale
    // data. Held addresses of x0 never match, because wb_addr must be
    // nonzero.
`ifdef ALU_ISSUE_FORWARD_EN
    assign refresh1 = wb_valid && (wb_addr != ADDR_WIDTH'(ZERO_REG))
                      && (wb_addr == held_rs1);
    assign refresh2 = wb_valid && (wb_addr != ADDR_WIDTH'(ZERO_REG))
                      && (wb_addr == held_rs2) && !held_use_imm;
`else
    assign refresh1 = 1'b0;
    assign refresh2 = 1'b0;
    logic unused_held;
    assign unused_held = ^{held_rs1, held_rs2, held_use_imm};
`endif

    // Priority, highest first: flush, new op, drain, stall-with-refresh.
    // flush and drain only clear the state; the stale data left in the
    // ex_* registers is masked because ex_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            ex_mode      <= ADD;
            ex_op1       <= '0;
            ex_op2       <= '0;
            ex_rd        <= '0;
            held_rs1     <= '0;
            held_rs2     <= '0;
            held_use_imm <= 1'b0;
        end else if (flush) begin
            state <= EMPTY;
        end else if (accept) begin
            state        <= FULL;
            ex_mode      <= in_mode;
            ex_op1       <= op1_sel;
            ex_op2       <= op2_sel;
            ex_rd        <= in_rd;
            held_rs1     <= in_rs1;
            held_rs2     <= in_rs2;
            held_use_imm <= in_use_imm;
        end else if ((state == FULL) && ex_ready) begin
            state <= EMPTY;
        end else if (state == FULL) begin
            if (refresh1) begin
                ex_op1 <= wb_data;
            end
            if (refresh2) begin
                ex_op2 <= wb_data;
            end
        end
    end

endmodule
